// File: rtl/ariane_irq_cond.sv
// ariane_irq_cond: per-hart interrupt line conditioning.
// Each raw line is synchronized, optionally glitch-filtered, then either passed
// through as a level or captured as a sticky pending bit on its rising edge.
// Each line is gated by its enable before it reaches the core.
module ariane_irq_cond #(
    parameter int unsigned        NrHarts      = 1,
    parameter int unsigned        NrLines      = 5,
    parameter int unsigned        SyncStages   = 2,
    parameter int unsigned        FilterCycles = 0,
    parameter logic [NrLines-1:0] EdgeMask     = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHarts-1:0][NrLines-1:0]   irq_i,
    input  logic [NrHarts-1:0][NrLines-1:0]   en_i,
    input  logic [NrHarts-1:0][NrLines-1:0]   clr_i,
    output logic [NrHarts-1:0][NrLines-1:0]   irq_o,
    output logic [NrHarts-1:0]                any_o
);

    for (genvar h = 0; h < NrHarts; h++) begin : g_hart
        for (genvar l = 0; l < NrLines; l++) begin : g_line
            logic [SyncStages-1:0] r_sync;
            logic                  w_sync;
            logic                  w_filt;
            logic                  w_lvl;

            // Synchronizer chain for the asynchronous raw line.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SyncStages-2:0], irq_i[h][l]};
                end
            end

            assign w_sync = r_sync[SyncStages-1];

            if (FilterCycles == 0) begin : g_nofilt
                assign w_filt = w_sync;
            end else begin : g_filt
                localparam int unsigned    CntW    = $clog2(FilterCycles + 1);
                localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

                logic [CntW-1:0] r_cnt;
                logic            r_filt;

                // Glitch filter: adopt a new value only after it has differed
                // from the filtered value for FilterCycles consecutive cycles.
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_cnt  <= '0;
                        r_filt <= 1'b0;
                    end else if (w_sync == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CntLast) begin
                        r_filt <= w_sync;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end

                assign w_filt = r_filt;
            end

            if (EdgeMask[l]) begin : g_edge
                logic r_filt_q;
                logic r_pend;
                logic w_rise;

                assign w_rise = w_filt & ~r_filt_q;

                // Sticky pending bit: a rising edge sets it and wins over a
                // simultaneous clear.
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_filt_q <= 1'b0;
                        r_pend   <= 1'b0;
                    end else begin
                        r_filt_q <= w_filt;
                        r_pend   <= w_rise | (r_pend & ~clr_i[h][l]);
                    end
                end

                assign w_lvl = r_pend;
            end else begin : g_level
                // Level lines have nothing to clear; the clear input is folded in
                // as a don't-care so the port stays referenced.
                assign w_lvl = w_filt & (clr_i[h][l] | 1'b1);
            end

            assign irq_o[h][l] = w_lvl & en_i[h][l];
        end

        assign any_o[h] = |irq_o[h];
    end

endmodule

// File: tb/tb_ariane_irq_cond.sv
// Directed bench for ariane_irq_cond with a due-cycle scoreboard.
// Instance A: 4 harts, no filter, line 4 in edge mode.
// Instance B: 1 hart, FilterCycles=3, line 4 in edge mode.
module tb_ariane_irq_cond;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0][4:0] irq_a, en_a, clr_a, irqo_a;
    logic [3:0]      any_a;
    logic [0:0][4:0] irq_b, en_b, clr_b, irqo_b;
    logic [0:0]      any_b;

    ariane_irq_cond #(
        .NrHarts(4), .NrLines(5), .SyncStages(2), .FilterCycles(0), .EdgeMask(5'b10000)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .irq_i(irq_a), .en_i(en_a), .clr_i(clr_a),
        .irq_o(irqo_a), .any_o(any_a)
    );

    ariane_irq_cond #(
        .NrHarts(1), .NrLines(5), .SyncStages(2), .FilterCycles(3), .EdgeMask(5'b10000)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .irq_i(irq_b), .en_i(en_b), .clr_i(clr_b),
        .irq_o(irqo_b), .any_o(any_b)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t         sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] obs_v;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return {12'b0, irqo_a};
            1:       return {28'b0, any_a};
            2:       return {27'b0, irqo_b};
            default: return {31'b0, any_b};
        endcase
    endfunction

    // Compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                obs_v = obs(sb[i].sel);
                checks++;
                assert (obs_v === sb[i].exp) else begin
                    failures++;
                    $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
                           sb[i].tag, obs_v, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int d, input int sel, input logic [31:0] v, input string tag);
        sb_t e;
        e.due = cyc + d;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pa(input int d, input logic [31:0] v, input string tag); push(d, 0, v, tag); endtask
    task automatic aa(input int d, input logic [31:0] v, input string tag); push(d, 1, v, tag); endtask
    task automatic pb(input int d, input logic [31:0] v, input string tag); push(d, 2, v, tag); endtask
    task automatic ab(input int d, input logic [31:0] v, input string tag); push(d, 3, v, tag); endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        irq_a = '0; en_a = '1; clr_a = '0;
        irq_b = '0; en_b = '1; clr_b = '0;
        tick(3);
        checks++;
        if ({irqo_a, any_a} !== '0) begin
            failures++;
            $error("FAIL rst_direct_a observed=%0h/%0h expected=0", irqo_a, any_a);
        end
        checks++;
        if ({irqo_b, any_b} !== '0) begin
            failures++;
            $error("FAIL rst_direct_b observed=%0h/%0h expected=0", irqo_b, any_b);
        end
        pa(0, 0, "rst_irq_a"); aa(0, 0, "rst_any_a");
        pb(0, 0, "rst_irq_b"); ab(0, 0, "rst_any_b");
        rst = 1'b0;
        tick(2);

        // Level line 3, hart 0: two-edge latency both ways.
        irq_a[0][3] = 1'b1;
        pa(1, 0, "lvl_rise_early"); pa(2, 32'h8, "lvl_rise"); aa(2, 1, "lvl_rise_any");
        tick(4);
        irq_a[0][3] = 1'b0;
        pa(1, 32'h8, "lvl_fall_early"); pa(2, 0, "lvl_fall"); aa(2, 0, "lvl_fall_any");
        tick(4);

        // Edge line 4, hart 0: one-cycle pulse captured, held until clear.
        irq_a[0][4] = 1'b1;
        pa(2, 0, "edge_early"); pa(3, 32'h10, "edge_set"); aa(3, 1, "edge_set_any");
        tick(1);
        irq_a[0][4] = 1'b0;
        tick(6);
        pa(0, 32'h10, "edge_hold");
        clr_a[0][4] = 1'b1;
        pa(1, 0, "edge_clr"); aa(1, 0, "edge_clr_any");
        tick(1);
        clr_a[0][4] = 1'b0;
        tick(3);

        // Hart 1 line 4: clear coincident with rise, then held-high after clear.
        irq_a[1][4] = 1'b1;
        pa(3, 32'h200, "setwins"); aa(3, 4'b0010, "setwins_any");
        tick(2);
        clr_a[1][4] = 1'b1;
        tick(1);
        clr_a[1][4] = 1'b0;
        tick(3);
        pa(0, 32'h200, "setwins_hold");
        clr_a[1][4] = 1'b1;
        pa(1, 0, "held_clr"); pa(4, 0, "held_no_reset");
        tick(1);
        clr_a[1][4] = 1'b0;
        tick(4);
        irq_a[1][4] = 1'b0;
        tick(4);
        irq_a[1][4] = 1'b1;
        pa(3, 32'h200, "rerise");
        tick(4);
        irq_a[1][4] = 1'b0;
        clr_a[1][4] = 1'b1;
        pa(1, 0, "rerise_clr");
        tick(1);
        clr_a[1][4] = 1'b0;
        tick(3);

        // Hart 2 line 4: capture continues while disabled, shows at enable.
        en_a[2][4]  = 1'b0;
        irq_a[2][4] = 1'b1;
        pa(3, 0, "en_off_rise"); aa(3, 0, "en_off_any");
        tick(1);
        irq_a[2][4] = 1'b0;
        tick(5);
        en_a[2][4] = 1'b1;
        pa(0, 32'h4000, "en_on"); aa(0, 4'b0100, "en_on_any");
        tick(1);
        clr_a[2][4] = 1'b1;
        pa(1, 0, "en_clr");
        tick(1);
        clr_a[2][4] = 1'b0;
        tick(2);

        // Distinct level patterns per hart.
        irq_a[0] = 5'b00001;
        irq_a[1] = 5'b00110;
        irq_a[3] = 5'b01000;
        pa(2, 32'h400C1, "harts"); aa(2, 4'b1011, "harts_any");
        tick(3);
        en_a[3][3] = 1'b0;
        pa(0, 32'h000C1, "harts_gate"); aa(0, 4'b0011, "harts_gate_any");
        tick(1);
        irq_a = '0;
        en_a  = '1;
        pa(2, 0, "harts_off"); aa(2, 0, "harts_off_any");
        tick(3);

        // Pending edge discarded by reset; held input re-detected after release.
        irq_a[0][4] = 1'b1;
        pa(3, 32'h10, "rst_pend_set");
        tick(5);
        rst = 1'b1;
        pa(1, 0, "rst_pend_clear"); aa(1, 0, "rst_pend_any"); pb(1, 0, "rst_b_quiet");
        tick(1);
        rst = 1'b0;
        pa(2, 0, "rel_early"); pa(3, 32'h10, "rel_edge"); aa(3, 1, "rel_edge_any");
        tick(4);
        irq_a[0][4] = 1'b0;
        clr_a[0][4] = 1'b1;
        pa(1, 0, "rel_clr");
        tick(1);
        clr_a[0][4] = 1'b0;
        tick(3);

        // Filtered instance: 2-cycle glitch never reaches the output.
        irq_b[0][0] = 1'b1;
        for (int d = 1; d <= 8; d++) pb(d, 0, "glitch");
        tick(2);
        irq_b[0][0] = 1'b0;
        tick(8);

        // Filtered level line: 4-cycle high shows exactly 5 edges after assertion.
        irq_b[0][0] = 1'b1;
        pb(4, 0, "filt_early"); pb(5, 1, "filt_rise"); ab(5, 1, "filt_rise_any");
        tick(4);
        irq_b[0][0] = 1'b0;
        pb(4, 1, "filt_fall_early"); pb(5, 0, "filt_fall");
        tick(7);

        // Filtered edge line: S+1+F latency.
        irq_b[0][4] = 1'b1;
        pb(5, 0, "filt_edge_early"); pb(6, 32'h10, "filt_edge");
        tick(4);
        irq_b[0][4] = 1'b0;
        tick(4);
        clr_b[0][4] = 1'b1;
        pb(1, 0, "filt_edge_clr");
        tick(1);
        clr_b[0][4] = 1'b0;
        tick(8);

        // Reset mid-count discards the partial filter count.
        irq_b[0][0] = 1'b1;
        tick(3);
        rst = 1'b1;
        pb(1, 0, "rst_partial");
        tick(1);
        rst = 1'b0;
        pb(4, 0, "post_rst_early"); pb(5, 1, "post_rst_rise");
        tick(6);
        irq_b[0][0] = 1'b0;
        tick(8);

        while (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL %s never_compared expected=%0h due=%0d", sb[0].tag, sb[0].exp, sb[0].due);
            void'(sb.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
